// File: rtl/cla_pipe_adder.sv
// Pipelined adder built from 2-bit carry-lookahead groups, one group per stage.
// Each stage resolves two sum bits, registers its group carry and forwards the untouched operand bits.
module cla_pipe_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / 2;
    localparam int LAST   = STAGES - 1;

    logic             r_valid [STAGES];
    logic             r_carry [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic             r_cmsb;

    logic             w_adv;
    logic             w_v     [STAGES];
    logic [WIDTH-1:0] w_a     [STAGES];
    logic [WIDTH-1:0] w_b     [STAGES];
    logic [WIDTH-1:0] w_s_in  [STAGES];
    logic             w_c0    [STAGES];
    logic [1:0]       w_p     [STAGES];
    logic [1:0]       w_g     [STAGES];
    logic             w_c1    [STAGES];
    logic             w_c2    [STAGES];
    logic [WIDTH-1:0] w_sum   [STAGES];

    // Handshake: a beat moves on an edge where valid & ready are both high.
    // The whole pipe advances together whenever the output slot is empty or
    // being drained, so in_ready mirrors that enable and a stall freezes every
    // stage, including bubbles.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    always_comb begin
        w_v[0]    = in_valid;
        w_a[0]    = a;
        w_b[0]    = b;
        w_c0[0]   = cin;
        w_s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_v[k]    = r_valid[k-1];
            w_a[k]    = r_a[k-1];
            w_b[k]    = r_b[k-1];
            w_c0[k]   = r_carry[k-1];
            w_s_in[k] = r_sum[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_p[k]   = w_a[k][2*k +: 2] ^ w_b[k][2*k +: 2];
            w_g[k]   = w_a[k][2*k +: 2] & w_b[k][2*k +: 2];
            w_c1[k]  = w_g[k][0] | (w_p[k][0] & w_c0[k]);
            w_c2[k]  = w_g[k][1] | (w_p[k][1] & w_g[k][0]) | (w_p[k][1] & w_p[k][0] & w_c0[k]);
            w_sum[k] = w_s_in[k];
            w_sum[k][2*k +: 2] = {w_p[k][1] ^ w_c1[k], w_p[k][0] ^ w_c0[k]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_carry[k] <= 1'b0;
                r_sum[k]   <= '0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
            end
            r_cmsb <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= w_v[k];
                // Bubbles only move the valid bit; data of the stage holds.
                if (w_v[k]) begin
                    r_carry[k] <= w_c2[k];
                    r_sum[k]   <= w_sum[k];
                    r_a[k]     <= w_a[k];
                    r_b[k]     <= w_b[k];
                end
            end
            if (w_v[LAST]) begin
                r_cmsb <= w_c1[LAST];
            end
        end
    end

    assign out_valid = r_valid[LAST];
    assign sum       = r_sum[LAST];
    assign cout      = r_carry[LAST];
    assign ovf       = r_cmsb ^ r_carry[LAST];
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder at WIDTH=8: directed corner sums, random streaming,
// stall and mid-stream reset, with an in-order expected queue checked at the output.
module tb_cla_pipe_adder;
  localparam int W      = 8;
  localparam int STAGES = W / 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];

  cla_pipe_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference: {cout, ovf, sum}; overflow from operand/result signs
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {t[W], v, t[W-1:0]};
  endfunction

  // scoreboard: push on accept, pop and compare on output transfer
  always @(negedge clk) begin
    logic [W+1:0] exp;
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_extra: got cout=%b ovf=%b sum=%h with no beat expected", cout, ovf, sum);
        end else begin
          exp = exp_q.pop_front();
          if ({cout, ovf, sum} !== exp) begin
            errors++;
            $display("FAIL scoreboard_data: got cout=%b ovf=%b sum=%h expected cout=%b ovf=%b sum=%h",
                     cout, ovf, sum, exp[W+1], exp[W], exp[W-1:0]);
          end
        end
      end
    end
  end

  // driver helpers
  task automatic rand_beat();
    a   = W'($urandom_range(0, 255));
    b   = W'($urandom_range(0, 255));
    cin = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 30 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b sum=%h cout=%b ovf=%b expected 0/00/0/0", out_valid, sum, cout, ovf);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_single(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                             input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf,
                             input string name);
    int cyc;
    out_ready = 1'b1;
    a = x; b = y; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != STAGES - 1) begin
      errors++;
      $display("FAIL %s_latency: output after %0d further edges, expected %0d", name, cyc, STAGES - 1);
    end
    checks++;
    if (sum !== e_sum || cout !== e_cout || ovf !== e_ovf) begin
      errors++;
      $display("FAIL %s_value: sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, e_sum, e_cout, e_ovf);
    end
    @(posedge clk); #1;
    drain(name);
  endtask

  task automatic test_back_to_back();
    logic e_v;
    out_ready = 1'b1;
    rand_beat();
    in_valid = 1'b1;
    for (int j = 1; j <= 32 + STAGES; j++) begin
      @(posedge clk); #1;
      e_v = (j >= STAGES) && (j <= 31 + STAGES);
      checks++;
      if (out_valid !== e_v) begin
        errors++;
        $display("FAIL b2b_rate: edge %0d out_valid=%b expected %b", j, out_valid, e_v);
      end
      if (j < 32) rand_beat();
      else in_valid = 1'b0;
    end
    drain("b2b");
  endtask

  task automatic test_stall();
    logic [W-1:0] s_sum;
    logic         s_cout;
    logic         s_ovf;
    out_ready = 1'b1;
    rand_beat();
    in_valid = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      rand_beat();
    end
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_enter: out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
    end
    s_sum = sum; s_cout = cout; s_ovf = ovf;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== s_sum || cout !== s_cout || ovf !== s_ovf) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b expected 1/0/%h/%b/%b",
                 s, out_valid, in_ready, sum, cout, ovf, s_sum, s_cout, s_ovf);
      end
    end
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_resume: cycle %0d out_valid=%b expected 1", j, out_valid);
      end
      rand_beat();
    end
    in_valid = 1'b0;
    drain("stall");
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_outputs: out_valid=%b sum=%h in_ready=%b expected 0/00/1", out_valid, sum, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_ghost: cycle %0d out_valid=%b sum=%h expected no output", j, out_valid, sum);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add_5a_3c");
    test_single(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "ripple_ff");
    test_single(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "neg_ovf");
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
